mult_table_checker: RTL and testbench

- Receiving end of the multiplication-table stream produced by the table generator.
- Consumes (index, result) beats over a valid/ready handshake and checks each against an internally tracked expected sequence: result == MULT*index, index stepping START_IDX..LAST_IDX.
- Reports pass/error counts, a per-beat mismatch pulse, a stall timeout and completion.
- Sits between the generator and the self-check/status logic of the table bench.

---
 rtl/mult_table_checker.sv | 191 +++++++++++++++++++
 tb/tb_mult_table_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_table_checker.sv
// mult_table_checker: receiving end of the multiplication-table stream.
// It takes (index, result) beats over a valid/ready handshake. Each beat is
// checked against an internally tracked sequence: index steps START_IDX..LAST_IDX
// and result == MULT*index.
//
// Ports:
//   clk        - single clock, all state on the rising edge
//   reset      - asynchronous active-low reset
//   start      - one-cycle pulse that arms a new run (wins over a same-cycle beat)
//   in_valid   - beat present on index/result
//   in_ready   - checker accepts a beat this cycle (registered, high in SYNC/CHECK)
//   index      - received table index
//   result     - received product
//   mismatch   - one-cycle pulse the cycle after a wrong beat is accepted
//   pass_count - correct beats in the current run, saturating at 255
//   err_count  - wrong beats in the current run, saturating at 255
//   timeout    - sticky, the stream stalled too long while checking
//   done       - run finished (normally or by timeout), held until start
module mult_table_checker #(
    parameter int unsigned MULT      = 3,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned RES_W     = 8,
    parameter int unsigned START_IDX = 1,
    parameter int unsigned LAST_IDX  = 10,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] index,
    input  logic [RES_W-1:0] result,
    output logic             mismatch,
    output logic [7:0]       pass_count,
    output logic [7:0]       err_count,
    output logic             timeout,
    output logic             done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(START_IDX);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LAST_IDX);
    localparam logic [RES_W-1:0] RES_START = RES_W'(MULT * START_IDX);
    localparam logic [RES_W-1:0] RES_STEP  = RES_W'(MULT);
    localparam logic [TO_W-1:0]  IDLE_MAX  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0] exp_idx;
    logic [RES_W-1:0] exp_res;
    logic [TO_W-1:0]  idle_cnt;

    logic [IDX_W-1:0] exp_idx_nxt;
    logic [RES_W-1:0] exp_res_nxt;
    logic [TO_W-1:0]  idle_cnt_nxt;
    logic [CNT_W-1:0] pass_count_nxt;
    logic [CNT_W-1:0] err_count_nxt;
    logic             in_ready_nxt;
    logic             mismatch_nxt;
    logic             timeout_nxt;
    logic             done_nxt;

    logic accept;
    logic sync_hit;
    logic last_beat;
    logic idle_expired;
    logic check_beat;
    logic beat_ok;

    assign accept       = in_valid & in_ready;
    assign sync_hit     = (index == IDX_START);
    assign last_beat    = (exp_idx == IDX_LAST);
    assign idle_expired = (idle_cnt == IDLE_MAX);
    assign beat_ok      = (index == exp_idx) && (result == exp_res);
    // A beat is scored in CHECK, or in SYNC once the first index shows up.
    assign check_beat   = accept && ((state == ST_CHECK) || ((state == ST_SYNC) && sync_hit));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start restarts the run from any state
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_SYNC;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_SYNC: begin
                    if (accept && sync_hit) begin
                        state_nxt = last_beat ? ST_DONE : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        state_nxt = last_beat ? ST_DONE : ST_CHECK;
                    end else if (idle_expired) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE:  state_nxt = ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        exp_idx_nxt    = exp_idx;
        exp_res_nxt    = exp_res;
        idle_cnt_nxt   = idle_cnt;
        pass_count_nxt = pass_count;
        err_count_nxt  = err_count;
        timeout_nxt    = timeout;
        mismatch_nxt   = 1'b0;
        in_ready_nxt   = (state_nxt == ST_SYNC) || (state_nxt == ST_CHECK);
        done_nxt       = (state_nxt == ST_DONE);

        if (start) begin
            exp_idx_nxt    = IDX_START;
            exp_res_nxt    = RES_START;
            idle_cnt_nxt   = '0;
            pass_count_nxt = '0;
            err_count_nxt  = '0;
            timeout_nxt    = 1'b0;
        end else begin
            if (check_beat) begin
                if (beat_ok) begin
                    if (pass_count != CNT_MAX) pass_count_nxt = pass_count + CNT_W'(1);
                end else begin
                    if (err_count != CNT_MAX) err_count_nxt = err_count + CNT_W'(1);
                    mismatch_nxt = 1'b1;
                end
                // The expected sequence advances regardless of correctness.
                exp_idx_nxt  = exp_idx + IDX_W'(1);
                exp_res_nxt  = exp_res + RES_STEP;
                idle_cnt_nxt = '0;
            end else if (state == ST_CHECK) begin
                if (idle_expired) begin
                    timeout_nxt = 1'b1;
                end else begin
                    idle_cnt_nxt = idle_cnt + TO_W'(1);
                end
            end
        end
    end

    // Output / datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_idx    <= IDX_START;
            exp_res    <= RES_START;
            idle_cnt   <= '0;
            pass_count <= '0;
            err_count  <= '0;
            in_ready   <= 1'b0;
            mismatch   <= 1'b0;
            timeout    <= 1'b0;
            done       <= 1'b0;
        end else begin
            exp_idx    <= exp_idx_nxt;
            exp_res    <= exp_res_nxt;
            idle_cnt   <= idle_cnt_nxt;
            pass_count <= pass_count_nxt;
            err_count  <= err_count_nxt;
            in_ready   <= in_ready_nxt;
            mismatch   <= mismatch_nxt;
            timeout    <= timeout_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mult_table_checker.sv
// Directed self-checking bench for mult_table_checker (default parameters).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mult_table_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] index;
    logic [7:0] result;
    logic       mismatch;
    logic [7:0] pass_count;
    logic [7:0] err_count;
    logic       timeout;
    logic       done;

    int checks;
    int errors;
    int mm_count;

    mult_table_checker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .index      (index),
        .result     (result),
        .mismatch   (mismatch),
        .pass_count (pass_count),
        .err_count  (err_count),
        .timeout    (timeout),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one beat for one cycle; in_ready is high in SYNC/CHECK so it is accepted.
    task automatic send(input logic [3:0] i, input logic [7:0] r);
        in_valid = 1'b1;
        index    = i;
        result   = r;
        step();
        in_valid = 1'b0;
        if (mismatch) mm_count++;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mm_count = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        index    = '0;
        result   = '0;

        // Reset values
        #1 reset = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_pass", 32'(pass_count), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        reset = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 0);

        // Clean run 1..10
        do_start();
        check("t1_ready_after_start", 32'(in_ready), 1);
        for (int i = 1; i <= 9; i++) send(4'(i), 8'(3 * i));
        check("t1_done_before_last", 32'(done), 0);
        send(4'd10, 8'd30);
        check("t1_done", 32'(done), 1);
        check("t1_pass", 32'(pass_count), 10);
        check("t1_err", 32'(err_count), 0);
        check("t1_timeout", 32'(timeout), 0);
        check("t1_mismatch_count", 32'(mm_count), 0);
        check("t1_ready_done", 32'(in_ready), 0);
        // Extra beats in DONE are not accepted
        in_valid = 1'b1;
        index    = 4'd11;
        result   = 8'd33;
        step();
        step();
        in_valid = 1'b0;
        check("t1_frozen_pass", 32'(pass_count), 10);
        check("t1_frozen_err", 32'(err_count), 0);

        // SYNC discards beats until index==1
        do_start();
        check("t2_pass_cleared", 32'(pass_count), 0);
        check("t2_done_cleared", 32'(done), 0);
        send(4'd0, 8'd0);
        send(4'd7, 8'd21);
        check("t2_discard_pass", 32'(pass_count), 0);
        check("t2_discard_err", 32'(err_count), 0);
        for (int i = 1; i <= 10; i++) send(4'(i), 8'(3 * i));
        check("t2_pass", 32'(pass_count), 10);
        check("t2_err", 32'(err_count), 0);
        check("t2_done", 32'(done), 1);

        // Single wrong result at index 4
        mm_count = 0;
        do_start();
        for (int i = 1; i <= 3; i++) send(4'(i), 8'(3 * i));
        check("t3_no_mm_before", 32'(mismatch), 0);
        send(4'd4, 8'd13);
        check("t3_mm_pulse", 32'(mismatch), 1);
        send(4'd5, 8'd15);
        check("t3_mm_cleared", 32'(mismatch), 0);
        for (int i = 6; i <= 10; i++) send(4'(i), 8'(3 * i));
        check("t3_pass", 32'(pass_count), 9);
        check("t3_err", 32'(err_count), 1);
        check("t3_done", 32'(done), 1);
        check("t3_mm_count", 32'(mm_count), 1);

        // Stall timeout after index 3
        do_start();
        for (int i = 1; i <= 3; i++) send(4'(i), 8'(3 * i));
        for (int i = 0; i < 15; i++) step();
        check("t4_no_timeout_15", 32'(timeout), 0);
        check("t4_no_done_15", 32'(done), 0);
        step();
        check("t4_timeout", 32'(timeout), 1);
        check("t4_done", 32'(done), 1);
        check("t4_pass", 32'(pass_count), 3);
        check("t4_ready", 32'(in_ready), 0);
        step();
        check("t4_timeout_sticky", 32'(timeout), 1);
        do_start();
        check("t4_restart_timeout", 32'(timeout), 0);
        check("t4_restart_done", 32'(done), 0);
        check("t4_restart_pass", 32'(pass_count), 0);
        check("t4_restart_ready", 32'(in_ready), 1);

        // Asynchronous reset during index 5
        for (int i = 1; i <= 4; i++) send(4'(i), 8'(3 * i));
        check("t5_pass_pre", 32'(pass_count), 4);
        in_valid = 1'b1;
        index    = 4'd5;
        result   = 8'd15;
        #3 reset = 1'b0;
        #1;
        check("t5_async_pass", 32'(pass_count), 0);
        check("t5_async_ready", 32'(in_ready), 0);
        check("t5_async_done", 32'(done), 0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        step();
        step();
        check("t5_idle_ready", 32'(in_ready), 0);
        do_start();
        for (int i = 1; i <= 10; i++) send(4'(i), 8'(3 * i));
        check("t5_pass", 32'(pass_count), 10);
        check("t5_done", 32'(done), 1);

        // start coinciding with an accepted beat
        do_start();
        for (int i = 1; i <= 5; i++) send(4'(i), 8'(3 * i));
        check("t6_pass_pre", 32'(pass_count), 5);
        start    = 1'b1;
        in_valid = 1'b1;
        index    = 4'd6;
        result   = 8'd18;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        check("t6_pass", 32'(pass_count), 0);
        check("t6_err", 32'(err_count), 0);
        check("t6_ready", 32'(in_ready), 1);
        check("t6_done", 32'(done), 0);
        send(4'd6, 8'd18);
        check("t6_sync_discard", 32'(pass_count), 0);
        send(4'd1, 8'd3);
        check("t6_sync_first", 32'(pass_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
